// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode/funct fields, ALU operations and datapath mux encodings.
// Optional feature macro: MC_JUMP_EN adds the JUMP state.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
`ifdef MC_JUMP_EN
        S_JUMP   = 4'd11,
`endif
        S_FAULT  = 4'd15
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operations
    localparam int         ALU_W   = 3;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Fault causes
    localparam logic [1:0] CAUSE_NONE        = 2'b00;
    localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL     = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct to ALU operation decoder. Unknown funct codes raise
// illegal and drive an all-zero operation so nothing undefined leaks out.
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [5:0]       funct,
    output logic [ALU_W-1:0] alu_ctl,
    output logic             illegal
);

    // Map funct to ALU operation and flag anything outside the supported set
    always_comb begin
        alu_ctl = {ALU_W{1'b0}};
        illegal = 1'b0;
        case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: begin
                alu_ctl = {ALU_W{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback over a shared ALU and unified memory with a req/ready handshake
// and a watchdog on memory accesses. Faults (memory timeout, illegal
// instruction) are sticky until rst_n.
// Optional feature macro: MC_JUMP_EN enables the j instruction (JUMP state);
// without it opcode 000010 is treated as illegal.
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_CNT_W   = 4,
    parameter int ALUCTRL_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 iord,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           pc_src,
    output logic                 pc_en,
    output logic                 fault,
    output logic [1:0]           fault_cause,
    output logic [3:0]           state_o
);

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  fault_q, fault_d;
    logic [1:0]            fault_cause_q, fault_cause_d;

    logic                  mem_req_s, iord_s, mem_write_s, ir_write_s;
    logic                  reg_dst_s, mem_to_reg_s, reg_write_s, alu_src_a_s;
    logic                  pc_write_s, branch_s;
    logic [1:0]            alu_src_b_s, pc_src_s;
    logic [ALU_W-1:0]      alu_ctl_s, exec_ctl_s;
    logic                  exec_illegal_s, wait_limit_s;
    logic                  go_fault_s;
    logic [1:0]            go_cause_s;

    mips_alu_decoder u_alu_dec (
        .funct   (funct),
        .alu_ctl (exec_ctl_s),
        .illegal (exec_illegal_s)
    );

    // The watchdog fires when the counter has reached the limit and memory is still not ready
    assign wait_limit_s = (wait_cnt_q == WAIT_CNT_W'(MEM_WAIT_MAX));

    // Next state and per-state datapath controls; fault entry requests raised here
    always_comb begin
        state_d      = state_q;
        mem_req_s    = 1'b0;
        iord_s       = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_dst_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = SRCB_B;
        alu_ctl_s    = {ALU_W{1'b0}};
        pc_src_s     = PCSRC_ALU;
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        go_fault_s   = 1'b0;
        go_cause_s   = CAUSE_NONE;

        case (state_q)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                alu_ctl_s   = ALU_ADD;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else if (wait_limit_s) begin
                    state_d    = S_FAULT;
                    go_fault_s = 1'b1;
                    go_cause_s = CAUSE_MEM_TIMEOUT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding
                alu_src_b_s = SRCB_IMM_SH2;
                alu_ctl_s   = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`else
                    OP_J: begin
                        state_d    = S_FAULT;
                        go_fault_s = 1'b1;
                        go_cause_s = CAUSE_ILLEGAL;
                    end
`endif
                    default: begin
                        state_d    = S_FAULT;
                        go_fault_s = 1'b1;
                        go_cause_s = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                alu_ctl_s   = ALU_ADD;
                if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_limit_s) begin
                    state_d    = S_FAULT;
                    go_fault_s = 1'b1;
                    go_cause_s = CAUSE_MEM_TIMEOUT;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_s   = 1'b1;
                iord_s      = 1'b1;
                mem_write_s = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_limit_s) begin
                    state_d    = S_FAULT;
                    go_fault_s = 1'b1;
                    go_cause_s = CAUSE_MEM_TIMEOUT;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_B;
                alu_ctl_s   = exec_ctl_s;
                if (exec_illegal_s) begin
                    state_d    = S_FAULT;
                    go_fault_s = 1'b1;
                    go_cause_s = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                reg_dst_s   = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_B;
                alu_ctl_s   = ALU_SUB;
                pc_src_s    = PCSRC_ALUOUT;
                branch_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                alu_ctl_s   = ALU_ADD;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                pc_src_s   = PCSRC_JUMP;
                pc_write_s = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                // Unreachable encodings are treated as a corrupted control state
                state_d    = S_FAULT;
                go_fault_s = 1'b1;
                go_cause_s = CAUSE_ILLEGAL;
            end
        endcase
    end

    // Fault latching (first cause wins) and memory watchdog counter update
    always_comb begin
        fault_d       = fault_q;
        fault_cause_d = fault_cause_q;
        wait_cnt_d    = {WAIT_CNT_W{1'b0}};
        if (go_fault_s && !fault_q) begin
            fault_d       = 1'b1;
            fault_cause_d = go_cause_s;
        end else begin
            fault_d       = fault_q;
            fault_cause_d = fault_cause_q;
        end
        if (mem_req_s && !mem_ready && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end else begin
            wait_cnt_d = {WAIT_CNT_W{1'b0}};
        end
    end

    // State, watchdog and fault registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            wait_cnt_q    <= {WAIT_CNT_W{1'b0}};
            fault_q       <= 1'b0;
            fault_cause_q <= CAUSE_NONE;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
        end
    end

    // Strobes are gated by rst_n so a reset mid-access drops them immediately
    assign mem_req     = mem_req_s & rst_n;
    assign mem_write   = mem_write_s & rst_n;
    assign ir_write    = ir_write_s & rst_n;
    assign reg_write   = reg_write_s & rst_n;
    assign pc_en       = (pc_write_s | (branch_s & zero)) & rst_n;
    assign iord        = iord_s;
    assign reg_dst     = reg_dst_s;
    assign mem_to_reg  = mem_to_reg_s;
    assign alu_src_a   = alu_src_a_s;
    assign alu_src_b   = alu_src_b_s;
    assign alu_control = ALUCTRL_W'(alu_ctl_s);
    assign pc_src      = pc_src_s;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Each instruction is turned
// into an expected per-cycle trace (state, outputs, and the mem_ready/zero
// stimulus for that cycle) built from the instruction's phase list, then
// replayed against the DUT.
module tb_mips_multicycle_ctrl;

    localparam int MAXW      = 15;
    localparam int ST_FETCH  = 0;
    localparam int ST_DECODE = 1;
    localparam int ST_MEMADR = 2;
    localparam int ST_MEMRD  = 3;
    localparam int ST_MEMWB  = 4;
    localparam int ST_MEMWR  = 5;
    localparam int ST_EXEC   = 6;
    localparam int ST_ALUWB  = 7;
    localparam int ST_BRANCH = 8;
    localparam int ST_ADDIEX = 9;
    localparam int ST_ADDIWB = 10;
`ifdef MC_JUMP_EN
    localparam int ST_JUMP   = 11;
`endif
    localparam int ST_FAULT  = 15;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, fault;
    logic [1:0] alu_src_b, pc_src, fault_cause;
    logic [2:0] alu_control;
    logic [3:0] state_o;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en), .fault(fault),
        .fault_cause(fault_cause), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy;
        logic        z;
        logic [3:0]  st;
        logic [18:0] outs;
    } cyc_t;

    cyc_t trace_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [18:0] obs_outs();
        return {mem_req, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_control, pc_src, pc_en, fault, fault_cause};
    endfunction

    function automatic logic [18:0] o(input logic mreq, input logic io, input logic mwr,
                                      input logic irw, input logic rw, input logic rdst,
                                      input logic m2r, input logic asa, input logic [1:0] asb,
                                      input logic [2:0] alu, input logic [1:0] psrc,
                                      input logic pcen);
        return {mreq, io, mwr, irw, rw, rdst, m2r, asa, asb, alu, psrc, pcen, 1'b0, 2'b00};
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic void push(input int st, input logic rdy, input logic z, input logic [18:0] outs);
        cyc_t c;
        c.rdy  = rdy;
        c.z    = z;
        c.st   = 4'(st);
        c.outs = outs;
        trace_q.push_back(c);
    endfunction

    function automatic void push_fault(input logic [1:0] cause);
        for (int i = 0; i < 3; i++) push(ST_FAULT, rnd(), rnd(), {16'd0, 1'b1, cause});
    endfunction

    // Outputs of a memory-access cycle; done marks the cycle memory answers
    function automatic logic [18:0] acc_outs(input int st, input logic done);
        if (st == ST_FETCH) return o(1'b1, 1'b0, 1'b0, done, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b01, 3'b010, 2'b00, done);
        else if (st == ST_MEMRD) return o(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                          2'b00, 3'b000, 2'b00, 1'b0);
        else return o(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    endfunction

    // Access with lat not-ready cycles; returns 1 if the watchdog fires first
    function automatic bit push_access(input int st, input int lat);
        for (int k = 0; k <= MAXW; k++) begin
            if (k == lat) begin
                push(st, 1'b1, rnd(), acc_outs(st, 1'b1));
                return 1'b0;
            end
            push(st, 1'b0, rnd(), acc_outs(st, 1'b0));
            if (k == MAXW) begin
                push_fault(2'b01);
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    // {legal, alu_control} for an R-type funct
    function automatic logic [3:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1010;
            6'b100010: return 4'b1110;
            6'b100100: return 4'b1000;
            6'b100101: return 4'b1001;
            6'b101010: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic bit build_instr(input logic [5:0] op, input logic [5:0] fn,
                                       input logic z, input int lat_f, input int lat_m);
        logic [3:0] r;
        if (push_access(ST_FETCH, lat_f)) return 1'b1;
        push(ST_DECODE, rnd(), rnd(), o(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0));
        case (op)
            LW, SW: begin
                push(ST_MEMADR, rnd(), rnd(), o(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
                if (op == LW) begin
                    if (push_access(ST_MEMRD, lat_m)) return 1'b1;
                    push(ST_MEMWB, rnd(), rnd(), o(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0));
                end else begin
                    if (push_access(ST_MEMWR, lat_m)) return 1'b1;
                end
            end
            RT: begin
                r = ref_alu(fn);
                push(ST_EXEC, rnd(), rnd(), o(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, r[2:0], 2'b00, 0));
                if (!r[3]) begin
                    push_fault(2'b10);
                    return 1'b1;
                end
                push(ST_ALUWB, rnd(), rnd(), o(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 3'b000, 2'b00, 0));
            end
            BEQ: push(ST_BRANCH, rnd(), z, o(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, z));
            ADDI: begin
                push(ST_ADDIEX, rnd(), rnd(), o(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0));
                push(ST_ADDIWB, rnd(), rnd(), o(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0));
            end
`ifdef MC_JUMP_EN
            J: push(ST_JUMP, rnd(), rnd(), o(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1));
`endif
            default: begin
                push_fault(2'b10);
                return 1'b1;
            end
        endcase
        return 1'b0;
    endfunction

    // Replay up to max_cyc trace cycles; entered and left at posedge+1
    task automatic run_trace(input int max_cyc);
        cyc_t c;
        int   n;
        n = 0;
        while (trace_q.size() > 0 && n < max_cyc) begin
            c = trace_q.pop_front();
            mem_ready = c.rdy;
            zero      = c.z;
            #3;
            check_eq("state", 32'(state_o), 32'(c.st));
            check_eq("outs", 32'(obs_outs()), 32'(c.outs));
            @(posedge clk);
            #1;
            n++;
        end
        trace_q.delete();
    endtask

    // Assert reset for one cycle, checking that strobes drop at once
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_state", 32'(state_o), 32'(ST_FETCH));
        check_eq("rst_strobes", 32'({mem_req, ir_write, pc_en, reg_write, mem_write, fault, fault_cause}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int lat_f, input int lat_m);
        bit faulted;
        opcode  = op;
        funct   = fn;
        faulted = build_instr(op, fn, z, lat_f, lat_m);
        run_trace(1000);
        if (faulted) do_reset();
    endtask

    logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        bit         faulted;
        int         sel, lf, lm;
        logic [5:0] op, fn;

        rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed: test-plan cases and watchdog boundaries
        run_instr(LW, 6'd0, 1'b0, 0, 0);
        run_instr(RT, 6'b100000, 1'b0, 0, 0);
        run_instr(RT, 6'b100010, 1'b0, 0, 0);
        run_instr(BEQ, 6'd0, 1'b1, 0, 0);
        run_instr(BEQ, 6'd0, 1'b0, 0, 0);
        run_instr(ADDI, 6'd0, 1'b0, 0, 0);
        run_instr(SW, 6'd0, 1'b0, 0, 2);
        run_instr(LW, 6'd0, 1'b0, 3, 1);
        run_instr(ADDI, 6'd0, 1'b0, MAXW, MAXW);
        run_instr(LW, 6'd0, 1'b0, 0, MAXW);
        run_instr(LW, 6'd0, 1'b0, 0, 40);
        run_instr(SW, 6'd0, 1'b0, 1, MAXW + 1);
        run_instr(ADDI, 6'd0, 1'b0, MAXW + 1, 0);
        run_instr(J, 6'd0, 1'b0, 0, 0);
        run_instr(RT, 6'b000111, 1'b0, 0, 0);
        run_instr(6'b111111, 6'd0, 1'b0, 0, 0);

        // Reset in the middle of a read and in the middle of a fetch
        opcode  = LW;
        faulted = build_instr(LW, 6'd0, 1'b0, 0, 8);
        run_trace(6);
        do_reset();
        opcode  = ADDI;
        faulted = build_instr(ADDI, 6'd0, 1'b0, 5, 0);
        run_trace(2);
        do_reset();

        // Randomized instruction stream
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            fn  = legal_fn[$urandom_range(0, 4)];
            case (sel)
                0, 1:    op = LW;
                2:       op = SW;
                3, 4:    op = RT;
                5:       op = BEQ;
                6:       op = ADDI;
                7:       op = J;
                8:       op = 6'($urandom);
                default: begin
                    op = RT;
                    fn = 6'($urandom);
                end
            endcase
            lf = ($urandom_range(0, 24) == 0) ? MAXW + 1 : $urandom_range(0, 4);
            lm = ($urandom_range(0, 24) == 0) ? MAXW + 1 : $urandom_range(0, 4);
            run_instr(op, fn, rnd(), lf, lm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
